// File: rtl/sysstart_pkg.sv
// Shared definitions for the TMS/SYSSTART line decoder: FSM encoding and
// default timing constants.
package sysstart_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        PULSE     = 2'd2,
        HOLD      = 2'd3
    } state_e;

    localparam int IDLE_CYCLES_DEF = 16;
    localparam int MIN_PULSE_DEF   = 1;
    localparam int MAX_PULSE_DEF   = 4;

endpackage

// File: rtl/sync_bit.sv
// Single-bit synchronizer: a SYNC_STAGES-deep flop chain that clears
// asynchronously on reset.
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d[0] = d_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // NOTE: state flops use non-blocking assignments so every stage samples
    // the pre-edge value of its neighbour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sysstart_decoder.sv
// Receiver for the shared TMS_SYSSTART line: passes TMS to the TAP and
// recovers a one-cycle start strobe from short pulses seen while TCK is idle.
module sysstart_decoder
    import sysstart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
    parameter int MIN_PULSE   = MIN_PULSE_DEF,
    parameter int MAX_PULSE   = MAX_PULSE_DEF,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tms_sysstart_i,
    input  logic             tck_i,
    output logic             tms_o,
    output logic             sysstart_o,
    output logic             running_o,
    output logic [CNT_W-1:0] start_count_o,
    output logic             reject_o
);

    localparam int IDLE_W  = $clog2(IDLE_CYCLES + 1);
    localparam int PULSE_W = $clog2(MAX_PULSE + 1);

    logic               tms_s;
    logic               tck_s;
    logic               tck_edge;
    logic               tck_idle;

    logic               tck_prev_q;
    logic [IDLE_W-1:0]  idle_cnt_q,  idle_cnt_d;
    state_e             state_q,     state_d;
    logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic               sysstart_q,  sysstart_d;
    logic               reject_q,    reject_d;
    logic               running_q,   running_d;
    logic [CNT_W-1:0]   count_q,     count_d;

    assign tms_o = tms_sysstart_i;

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tms (
        .clk   (clk),
        .reset (reset),
        .d_i   (tms_sysstart_i),
        .q_o   (tms_s)
    );

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tck (
        .clk   (clk),
        .reset (reset),
        .d_i   (tck_i),
        .q_o   (tck_s)
    );

    assign tck_edge = tck_s ^ tck_prev_q;
    assign tck_idle = (idle_cnt_q == IDLE_W'(IDLE_CYCLES));

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        idle_cnt_d  = idle_cnt_q;
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        sysstart_d  = 1'b0;
        reject_d    = 1'b0;
        running_d   = running_q;
        count_d     = count_q;

        if (tck_edge) begin
            idle_cnt_d = '0;
        end else if (!tck_idle) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end

        case (state_q)
            WAIT_IDLE: begin
                if (tck_idle && !tms_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (tck_edge) begin
                    state_d = WAIT_IDLE;
                end else if (tms_s) begin
                    state_d     = PULSE;
                    pulse_cnt_d = PULSE_W'(1);
                end
            end
            PULSE: begin
                // TCK activity always overrides the line level, even on the falling cycle.
                if (tck_edge) begin
                    reject_d = 1'b1;
                    state_d  = WAIT_IDLE;
                end else if (tms_s) begin
                    if (pulse_cnt_q == PULSE_W'(MAX_PULSE)) begin
                        reject_d = 1'b1;
                        state_d  = HOLD;
                    end else begin
                        pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
                    end
                end else if (pulse_cnt_q >= PULSE_W'(MIN_PULSE)) begin
                    sysstart_d = 1'b1;
                    running_d  = 1'b1;
                    count_d    = count_q + CNT_W'(1);
                    state_d    = IDLE;
                end else begin
                    reject_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            HOLD: begin
                if (!tms_s) begin
                    state_d = WAIT_IDLE;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tck_prev_q  <= 1'b0;
            idle_cnt_q  <= '0;
            state_q     <= WAIT_IDLE;
            pulse_cnt_q <= '0;
            sysstart_q  <= 1'b0;
            reject_q    <= 1'b0;
            running_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            tck_prev_q  <= tck_s;
            idle_cnt_q  <= idle_cnt_d;
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            sysstart_q  <= sysstart_d;
            reject_q    <= reject_d;
            running_q   <= running_d;
            count_q     <= count_d;
        end
    end

    assign sysstart_o    = sysstart_q;
    assign reject_o      = reject_q;
    assign running_o     = running_q;
    assign start_count_o = count_q;

endmodule

// File: tb/tb_sysstart_decoder.sv
// Scoreboard bench for sysstart_decoder: expected strobes are queued with
// their arrival cycle when stimulus is driven and matched as they appear.
module tb_sysstart_decoder;

    localparam int SS    = 2;
    localparam int IDLE  = 16;
    localparam int MAXP  = 4;
    localparam int CNT_W = 8;

    typedef enum int {EV_ACCEPT = 0, EV_REJECT = 1} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       cyc;
    } ev_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             tms;
    logic             tck;
    logic             tms_o;
    logic             sysstart_o;
    logic             running_o;
    logic [CNT_W-1:0] start_count_o;
    logic             reject_o;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    int  exp_count = 0;
    bit  exp_running = 1'b0;
    ev_t exp_q[$];

    sysstart_decoder #(
        .SYNC_STAGES (SS),
        .IDLE_CYCLES (IDLE),
        .MIN_PULSE   (1),
        .MAX_PULSE   (MAXP),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tms_sysstart_i (tms),
        .tck_i          (tck),
        .tms_o          (tms_o),
        .sysstart_o     (sysstart_o),
        .running_o      (running_o),
        .start_count_o  (start_count_o),
        .reject_o       (reject_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: matches strobes against the queue; flags late/missing and unexpected events.
    always @(negedge clk) begin
        ev_t ev;
        if (reset) begin
            exp_count   = 0;
            exp_running = 1'b0;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                ev = exp_q.pop_front();
                check("missed_event", cyc, ev.cyc);
            end
            if (sysstart_o || reject_o) begin
                check("strobe_exclusive", 32'(sysstart_o & reject_o), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {30'd0, sysstart_o, reject_o}, 0);
                end else begin
                    ev = exp_q.pop_front();
                    check("event_kind", sysstart_o ? 0 : 1, 32'(ev.kind));
                    check("event_cycle", cyc, ev.cyc);
                    if (ev.kind == EV_ACCEPT) begin
                        exp_count   = (exp_count + 1) % (1 << CNT_W);
                        exp_running = 1'b1;
                    end
                    check("start_count", start_count_o, exp_count);
                    check("running", running_o, 32'(exp_running));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // High pulse of len clk cycles; armed means the decoder is idle and should react.
    task automatic pulse(input int len, input bit armed);
        int rise;
        @(negedge clk);
        tms  = 1'b1;
        rise = cyc;
        if (armed && len > MAXP) exp_q.push_back('{EV_REJECT, rise + 1 + SS + MAXP});
        repeat (len) @(negedge clk);
        tms = 1'b0;
        if (armed && len <= MAXP) exp_q.push_back('{EV_ACCEPT, cyc + 1 + SS});
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_sysstart"}, 32'(sysstart_o), 0);
        check({tag, "_reject"},   32'(reject_o), 0);
        check({tag, "_running"},  32'(running_o), 0);
        check({tag, "_count"},    start_count_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        tms   = 1'b0;
        tck   = 1'b0;
        idle(3);
        check_zero_outputs("reset");
        tms = 1'b1;
        #1 check("tms_in_reset_hi", 32'(tms_o), 1);
        tms = 1'b0;
        #1 check("tms_in_reset_lo", 32'(tms_o), 0);
        @(negedge clk) reset = 1'b0;

        // Basic start after an idle period
        idle(20);
        pulse(2, 1'b1);
        idle(10);
        check("running_after_first", 32'(running_o), 1);
        check("count_after_first", start_count_o, 1);

        // Back-to-back pulses with one low cycle, then the length boundaries
        pulse(2, 1'b1);
        pulse(1, 1'b1);
        idle(5);
        pulse(MAXP, 1'b1);
        idle(5);
        pulse(MAXP + 1, 1'b1);
        idle(20);

        // Overlong pulse: a single reject and no count change
        pulse(10, 1'b1);
        idle(20);
        check("count_after_overlong", start_count_o, exp_count);
        check("running_after_overlong", 32'(running_o), 1);

        // TCK edge on the same cycle the line falls: reject wins
        @(negedge clk) tms = 1'b1;
        repeat (2) @(negedge clk);
        tms = 1'b0;
        tck = ~tck;
        exp_q.push_back('{EV_REJECT, cyc + 1 + SS});
        idle(25);

        // TCK edge mid-pulse, then a pulse inside the re-qualification window is ignored
        @(negedge clk) tms = 1'b1;
        @(negedge clk) tck = ~tck;
        exp_q.push_back('{EV_REJECT, cyc + 1 + SS});
        repeat (2) @(negedge clk);
        tms = 1'b0;
        idle(4);
        pulse(2, 1'b0);
        idle(25);
        pulse(2, 1'b1);
        idle(20);

        // JTAG traffic: no starts, TMS passes straight through
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i % 2 == 0) tck = ~tck;
            tms = 1'($urandom_range(0, 1));
            #1 check("tms_passthrough", 32'(tms_o), 32'(tms));
        end
        @(negedge clk) tms = 1'b0;
        idle(25);
        check("queue_before_wrap", exp_q.size(), 0);

        // Counter wrap from a fresh reset
        @(negedge clk) reset = 1'b1;
        idle(2);
        @(negedge clk) reset = 1'b0;
        idle(25);
        for (int i = 0; i < 256; i++) begin
            pulse(2, 1'b1);
            idle(20);
        end
        check("count_wrapped", start_count_o, 0);
        check("running_after_wrap", 32'(running_o), 1);

        // Reset asserted and released while the line is high
        @(negedge clk) tms = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1 check_zero_outputs("async_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("after_reset_hi");
        tms = 1'b0;
        idle(8);
        check_zero_outputs("after_reset_lo");
        idle(20);
        pulse(2, 1'b1);
        idle(10);
        check("count_after_reset", start_count_o, 1);
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
